// File: rtl/fetch_sequencer.sv
// Instruction fetch stage: PC, variable-latency program-memory read, valid/ready hand-off to the decoder.
// Optional retired-instruction counter when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer #(
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        MAX_WAIT = 15,
    parameter logic [15:0]        NOP_WORD = 16'h1700
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [15:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic              fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       retired_cnt
`endif
);

    localparam int unsigned         WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   pc_reg;
    logic [WAIT_W-1:0]   wait_cnt_reg;
    logic [15:0]         instr_reg;
    logic                instr_valid_reg;
    logic                mem_rd_reg;
    logic                fault_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            pc_reg          <= RESET_PC;
            wait_cnt_reg    <= '0;
            instr_reg       <= NOP_WORD;
            instr_valid_reg <= 1'b0;
            mem_rd_reg      <= 1'b0;
            fault_reg       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    // A redirect while parked only moves the PC; fetching resumes on a later cycle.
                    if (pc_load) begin
                        pc_reg <= pc_target;
                    end else if (run && !fault_reg) begin
                        state_reg  <= S_REQ;
                        mem_rd_reg <= 1'b1;
                    end
                end

                S_REQ: begin
                    mem_rd_reg   <= 1'b1;
                    wait_cnt_reg <= '0;
                    if (pc_load) begin
                        pc_reg <= pc_target;
                    end else begin
                        state_reg <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (pc_load) begin
                        // Abandon the read; any data returning this cycle belongs to the old PC.
                        pc_reg     <= pc_target;
                        state_reg  <= S_REQ;
                        mem_rd_reg <= 1'b1;
                    end else if (mem_valid) begin
                        instr_reg       <= mem_rdata;
                        instr_valid_reg <= 1'b1;
                        mem_rd_reg      <= 1'b0;
                        state_reg       <= S_HOLD;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        fault_reg    <= 1'b1;
                        mem_rd_reg   <= 1'b0;
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                        state_reg    <= S_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (pc_load || instr_ready) begin
                        instr_valid_reg <= 1'b0;
                        instr_reg       <= NOP_WORD;
                        pc_reg          <= pc_load ? pc_target : pc_reg + 1'b1;
                        if (pc_load || run) begin
                            state_reg  <= S_REQ;
                            mem_rd_reg <= 1'b1;
                        end else begin
                            state_reg  <= S_IDLE;
                            mem_rd_reg <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_reg       <= S_IDLE;
                    instr_reg       <= NOP_WORD;
                    instr_valid_reg <= 1'b0;
                    mem_rd_reg      <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] retired_cnt_reg;

    // A word retires on every accepted hand-off, including one that coincides with a redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            retired_cnt_reg <= '0;
        end else if (instr_valid_reg && instr_ready && (retired_cnt_reg != 16'hFFFF)) begin
            retired_cnt_reg <= retired_cnt_reg + 16'd1;
        end
    end

    assign retired_cnt = retired_cnt_reg;
`endif

    assign mem_addr    = pc_reg;
    assign mem_rd      = mem_rd_reg;
    assign instr       = instr_reg;
    assign instr_valid = instr_valid_reg;
    assign fault       = fault_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: randomized memory latency, stalls and redirects
// checked against a word-level model (program contents function + expected PC).
module tb_fetch_sequencer;

    localparam logic [15:0] NOP = 16'h1700;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        fault;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] retired_cnt;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_pc;
    int          exp_ret;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .fault       (fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Program memory contents as a pure function of address.
    function automatic logic [15:0] prog_word(input logic [15:0] a);
        return {a[3:0], a[15:4]} ^ 16'hC3A5 ^ {a[7:0], 8'h00};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        run         = 1'b0;
        mem_valid   = 1'b0;
        instr_ready = 1'b0;
        pc_load     = 1'b0;
        mem_rdata   = 16'($urandom);
        pc_target   = 16'($urandom);
        step();
        step();
        reset   = 1'b1;
        exp_pc  = 16'h0000;
        exp_ret = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b1; pc_load = 1'b1; pc_target = 16'h1234;
        mem_valid = 1'b1; mem_rdata = 16'hBEEF; instr_ready = 1'b1;
        step(); step();
        n_cmp++; if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
        n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL reset_rd: got %b want 0", mem_rd); end
        n_cmp++; if (instr !== NOP) begin n_bad++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", fault); end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (retired_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_retired: got %0d want 0", retired_cnt); end
`endif
        pc_load = 1'b0; mem_valid = 1'b0; instr_ready = 1'b0;
        reset = 1'b1;
        step();
        n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_first_req: got rd=%b addr=%h want rd=1 addr=0000", mem_rd, mem_addr); end
        // Reset in the middle of a read with data arriving on the same edge.
        step();
        reset = 1'b0; mem_valid = 1'b1; mem_rdata = 16'h5555;
        step();
        reset = 1'b1; mem_valid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || instr !== NOP || mem_rd !== 1'b0) begin n_bad++; $display("FAIL reset_midfetch: got valid=%b instr=%h rd=%b want 0/%h/0", instr_valid, instr, mem_rd, NOP); end
        run = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_stream();
        do_reset();
        run = 1'b1;
        step();
        for (int w = 0; w < 10; w++) begin
            n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== exp_pc) begin n_bad++; $display("FAIL stream_req: got rd=%b addr=%h want rd=1 addr=%h", mem_rd, mem_addr, exp_pc); end
            step();
            mem_valid = 1'b1; mem_rdata = prog_word(exp_pc);
            step();
            mem_valid = 1'b0;
            n_cmp++; if (instr_valid !== 1'b1 || instr !== prog_word(exp_pc)) begin n_bad++; $display("FAIL stream_word: got valid=%b instr=%h want 1/%h", instr_valid, instr, prog_word(exp_pc)); end
            $display("stream word addr=%h instr=%h", exp_pc, instr);
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
            n_cmp++; if (instr_valid !== 1'b0 || instr !== NOP) begin n_bad++; $display("FAIL stream_consumed: got valid=%b instr=%h want 0/%h", instr_valid, instr, NOP); end
            exp_pc++;
            exp_ret++;
        end
        n_cmp++; if (mem_addr !== 16'd10 || mem_rd !== 1'b1) begin n_bad++; $display("FAIL stream_end: got addr=%h rd=%b want 000a/1", mem_addr, mem_rd); end
        $display("test_stream done retired_model=%0d", exp_ret);
    endtask

    task automatic test_stall_and_park();
        do_reset();
        run = 1'b1;
        step();
        step();
        run = 1'b0;
        mem_valid = 1'b1; mem_rdata = prog_word(16'h0000);
        step();
        mem_valid = 1'b0; mem_rdata = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (instr !== prog_word(16'h0000) || instr_valid !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 16'h0000) begin n_bad++; $display("FAIL stall_%0d: got instr=%h valid=%b rd=%b addr=%h want %h/1/0/0000", i, instr, instr_valid, mem_rd, mem_addr, prog_word(16'h0000)); end
        end
        instr_ready = 1'b1;
        step();
        // Parked: further ready pulses must not disturb anything.
        repeat (4) step();
        instr_ready = 1'b0;
        n_cmp++; if (mem_rd !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 16'h0001) begin n_bad++; $display("FAIL park: got rd=%b valid=%b addr=%h want 0/0/0001", mem_rd, instr_valid, mem_addr); end
        run = 1'b1;
        step();
        n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0001) begin n_bad++; $display("FAIL unpark: got rd=%b addr=%h want 1/0001", mem_rd, mem_addr); end
        $display("test_stall_and_park done");
    endtask

    task automatic test_redirect();
        do_reset();
        run = 1'b1;
        step();
        step();
        pc_load = 1'b1; pc_target = 16'h0040; mem_valid = 1'b1; mem_rdata = 16'hDEAD;
        step();
        pc_load = 1'b0; mem_valid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || instr !== NOP) begin n_bad++; $display("FAIL redir_wait_drop: got valid=%b instr=%h want 0/%h", instr_valid, instr, NOP); end
        n_cmp++; if (mem_addr !== 16'h0040 || mem_rd !== 1'b1) begin n_bad++; $display("FAIL redir_wait_addr: got addr=%h rd=%b want 0040/1", mem_addr, mem_rd); end
        step();
        mem_valid = 1'b1; mem_rdata = prog_word(16'h0040);
        step();
        mem_valid = 1'b0;
        n_cmp++; if (instr !== prog_word(16'h0040) || instr_valid !== 1'b1) begin n_bad++; $display("FAIL redir_word: got %h/%b want %h/1", instr, instr_valid, prog_word(16'h0040)); end
        instr_ready = 1'b1; pc_load = 1'b1; pc_target = 16'h0040;
        step();
        instr_ready = 1'b0; pc_load = 1'b0;
        n_cmp++; if (mem_addr !== 16'h0040 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_hold: got addr=%h valid=%b want 0040/0", mem_addr, instr_valid); end
        $display("test_redirect done");
    endtask

    task automatic test_timeout();
        do_reset();
        run = 1'b1;
        step();
        step();
        mem_valid = 1'b0;
        repeat (14) step();
        n_cmp++; if (mem_rd !== 1'b1 || fault !== 1'b0) begin n_bad++; $display("FAIL wait14: got rd=%b fault=%b want 1/0", mem_rd, fault); end
        mem_valid = 1'b1; mem_rdata = prog_word(16'h0000);
        step();
        mem_valid = 1'b0;
        n_cmp++; if (instr !== prog_word(16'h0000) || instr_valid !== 1'b1) begin n_bad++; $display("FAIL late_word: got %h/%b want %h/1", instr, instr_valid, prog_word(16'h0000)); end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        step();
        repeat (14) step();
        n_cmp++; if (fault !== 1'b0 || mem_rd !== 1'b1) begin n_bad++; $display("FAIL prefault: got fault=%b rd=%b want 0/1", fault, mem_rd); end
        step();
        n_cmp++; if (fault !== 1'b1 || mem_rd !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL fault_set: got fault=%b rd=%b valid=%b want 1/0/0", fault, mem_rd, instr_valid); end
        mem_valid = 1'b1; mem_rdata = 16'h9999;
        repeat (5) step();
        mem_valid = 1'b0;
        n_cmp++; if (fault !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 16'h0001 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL fault_hold: got fault=%b rd=%b addr=%h valid=%b want 1/0/0001/0", fault, mem_rd, mem_addr, instr_valid); end
        pc_load = 1'b1; pc_target = 16'h0ABC;
        step();
        pc_load = 1'b0;
        step();
        n_cmp++; if (mem_addr !== 16'h0ABC || mem_rd !== 1'b0 || fault !== 1'b1) begin n_bad++; $display("FAIL fault_pcload: got addr=%h rd=%b fault=%b want 0abc/0/1", mem_addr, mem_rd, fault); end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (retired_cnt !== 16'd1) begin n_bad++; $display("FAIL fault_retired: got %0d want 1", retired_cnt); end
`endif
        do_reset();
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL fault_clear: got %b want 0", fault); end
        run = 1'b1;
        step();
        n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin n_bad++; $display("FAIL after_fault_req: got rd=%b addr=%h want 1/0000", mem_rd, mem_addr); end
        $display("test_timeout done");
    endtask

    task automatic test_wrap();
        do_reset();
        run = 1'b1;
        step();
        pc_load = 1'b1; pc_target = 16'hFFFF;
        step();
        pc_load = 1'b0;
        exp_pc = 16'hFFFF;
        for (int w = 0; w < 3; w++) begin
            n_cmp++; if (mem_addr !== exp_pc || mem_rd !== 1'b1) begin n_bad++; $display("FAIL wrap_req%0d: got addr=%h rd=%b want %h/1", w, mem_addr, mem_rd, exp_pc); end
            step();
            mem_valid = 1'b1; mem_rdata = prog_word(exp_pc);
            step();
            mem_valid = 1'b0;
            n_cmp++; if (instr !== prog_word(exp_pc)) begin n_bad++; $display("FAIL wrap_word%0d: got %h want %h", w, instr, prog_word(exp_pc)); end
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
            exp_pc = exp_pc + 16'd1;
            exp_ret++;
        end
        n_cmp++; if (mem_addr !== 16'h0002) begin n_bad++; $display("FAIL wrap_end: got %h want 0002", mem_addr); end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (retired_cnt !== 16'd3) begin n_bad++; $display("FAIL wrap_retired: got %0d want 3", retired_cnt); end
`endif
        $display("test_wrap done retired_model=%0d", exp_ret);
    endtask

    task automatic test_random(input int n);
        int          kind;
        int          lat;
        int          stall;
        logic        rdy;
        logic [15:0] tgt;
        do_reset();
        run = 1'b1;
        step();
        for (int w = 0; w < n; w++) begin
            n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== exp_pc) begin n_bad++; $display("FAIL rnd_req%0d: got rd=%b addr=%h want 1/%h", w, mem_rd, mem_addr, exp_pc); end
            kind = int'($urandom_range(0, 7));
            tgt  = 16'($urandom);
            // Data strobed during the request cycle must be ignored.
            mem_valid = 1'($urandom); mem_rdata = 16'($urandom);
            if (kind == 0) begin
                pc_load = 1'b1; pc_target = tgt;
                step();
                pc_load = 1'b0; mem_valid = 1'b0;
                exp_pc = tgt;
                $display("rnd %0d redirect in request -> %h", w, tgt);
                continue;
            end
            step();
            lat = int'($urandom_range(0, 10));
            for (int i = 0; i < lat; i++) begin
                mem_valid = 1'b0; instr_ready = 1'($urandom);
                step();
                n_cmp++; if (instr_valid !== 1'b0 || instr !== NOP) begin n_bad++; $display("FAIL rnd_wait%0d: got valid=%b instr=%h want 0/%h", w, instr_valid, instr, NOP); end
            end
            instr_ready = 1'b0;
            if (kind == 1) begin
                mem_valid = 1'b1; mem_rdata = 16'hDEAD; pc_load = 1'b1; pc_target = tgt;
                step();
                mem_valid = 1'b0; pc_load = 1'b0;
                n_cmp++; if (instr_valid !== 1'b0 || instr !== NOP) begin n_bad++; $display("FAIL rnd_wait_redir%0d: got valid=%b instr=%h want 0/%h", w, instr_valid, instr, NOP); end
                exp_pc = tgt;
                $display("rnd %0d redirect in wait -> %h", w, tgt);
                continue;
            end
            mem_valid = 1'b1; mem_rdata = prog_word(exp_pc);
            step();
            mem_valid = 1'b0; mem_rdata = 16'($urandom);
            n_cmp++; if (instr_valid !== 1'b1 || instr !== prog_word(exp_pc)) begin n_bad++; $display("FAIL rnd_word%0d: got valid=%b instr=%h want 1/%h", w, instr_valid, instr, prog_word(exp_pc)); end
            stall = int'($urandom_range(0, 3));
            for (int i = 0; i < stall; i++) begin
                step();
                n_cmp++; if (instr !== prog_word(exp_pc) || instr_valid !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== exp_pc) begin n_bad++; $display("FAIL rnd_stall%0d: got instr=%h valid=%b rd=%b addr=%h", w, instr, instr_valid, mem_rd, mem_addr); end
            end
            if (kind == 2) begin
                rdy = 1'($urandom);
                pc_load = 1'b1; pc_target = tgt; instr_ready = rdy;
                step();
                pc_load = 1'b0; instr_ready = 1'b0;
                n_cmp++; if (instr_valid !== 1'b0 || instr !== NOP) begin n_bad++; $display("FAIL rnd_hold_redir%0d: got valid=%b instr=%h want 0/%h", w, instr_valid, instr, NOP); end
                if (rdy) exp_ret++;
                $display("rnd %0d addr=%h instr=%h redirect in hold ready=%b -> %h", w, exp_pc, prog_word(exp_pc), rdy, tgt);
                exp_pc = tgt;
                continue;
            end
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
            n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_consume%0d: got valid=%b want 0", w, instr_valid); end
            $display("rnd %0d addr=%h instr=%h lat=%0d stall=%0d", w, exp_pc, prog_word(exp_pc), lat, stall);
            exp_pc = exp_pc + 16'd1;
            exp_ret++;
        end
        n_cmp++; if (mem_addr !== exp_pc) begin n_bad++; $display("FAIL rnd_final_pc: got %h want %h", mem_addr, exp_pc); end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (int'(retired_cnt) !== exp_ret) begin n_bad++; $display("FAIL rnd_retired: got %0d want %0d", retired_cnt, exp_ret); end
`endif
        $display("test_random done retired_model=%0d", exp_ret);
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; mem_valid = 1'b0; instr_ready = 1'b0;
        pc_load = 1'b0; pc_target = 16'h0000; mem_rdata = 16'h0000;
        exp_pc = 16'h0000; exp_ret = 0;
        test_reset();
        test_stream();
        test_stall_and_park();
        test_redirect();
        test_timeout();
        test_wrap();
        test_random(60);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
